c7bbiu: RTL and testbench
=========================

Name: c7bbiu

Overview:
- Bus interface unit sitting directly downstream of c7blsu.
- Accepts the LSU's LS2 read/write requests, runs them one at a time on a simple req/gnt/rvalid 64-bit system bus, and returns completions to the LSU in LS3.
- Provides the read data, write-done and bus-error signals that c7blsu consumes.

Parameters:
- TIMEOUT_CYCLES, 255: response-wait limit, used only when BIU_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- clk  in  1  core clock; all state on rising edge
- resetn  in  1  asynchronous active-low reset
- lsu_biu_rd_req_ls2  in  1  LSU read request; held until acked
- lsu_biu_rd_addr_ls2  in  32  read byte address
- biu_lsu_rd_ack_ls2  out  1  read request accepted this cycle
- biu_lsu_data_valid_ls3  out  1  one-cycle read completion pulse
- biu_lsu_data_ls3  out  64  read data; valid with data_valid
- lsu_biu_wr_req_ls2  in  1  LSU write request; held until acked
- lsu_biu_wr_addr_ls2  in  32  write byte address
- lsu_biu_wr_data_ls2  in  64  write data, lane-aligned
- lsu_biu_wr_strb_ls2  in  8  byte enables
- biu_lsu_wr_ack_ls2  out  1  write request accepted this cycle
- biu_lsu_wr_done_ls3  out  1  one-cycle write completion pulse
- biu_lsu_buserr_ls3  out  1  error flag, qualifies a data_valid or wr_done pulse
- bus_req  out  1  system bus request
- bus_we  out  1  1 = write
- bus_addr  out  32  8-byte aligned address ({addr[31:3],3'b000})
- bus_wdata  out  64  write data
- bus_strb  out  8  byte enables; 8'hFF for reads
- bus_gnt  in  1  bus accepted request this cycle
- bus_rvalid  in  1  response valid (reads and writes)
- bus_rdata  in  64  read response data
- bus_err  in  1  response error, qualifies bus_rvalid

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE.
  - All outputs 0, including bus_req, the LS3 pulses, biu_lsu_data_ls3 and bus_addr/wdata/strb.
  - Reset mid-transaction abandons it silently; no completion pulse is ever emitted for it.
- Single outstanding transaction. States: IDLE, BREQ, BRESP.
- Accept in IDLE:
  - rd_ack = (state==IDLE) & rd_req, combinational.
  - wr_ack = (state==IDLE) & wr_req & ~rd_req. Read wins if both are requested; the write stays pending.
  - Acks are 0 in every other state.
- On an ack:
  - Latch addr, we, wdata and strb into registers. Reads latch wdata=0 and strb=8'hFF.
  - Transition to BREQ.
- BREQ:
  - bus_req=1, driven from the latched registers.
  - Bus fields are stable until bus_gnt.
  - bus_gnt=1 -> BRESP, with bus_req=0 the next cycle.
- BRESP:
  - bus_req=0.
  - bus_rvalid=1 -> IDLE.
  - In the next cycle (registered):
    - data_valid_ls3=1 and data_ls3=bus_rdata for a read; wr_done_ls3=1 for a write.
    - buserr_ls3=bus_err.
  - data_ls3 holds its last value after the pulse. On an error read, data_ls3 is 0.
- bus_rvalid in IDLE or BREQ is ignored.
- Minimum latency: ack at cycle 0 (IDLE), bus_req at cycle 1, gnt at cycle 1 (BREQ, same cycle), rvalid at cycle 2 (BRESP), completion pulse at cycle 3.
- Back-to-back:
  - A new request can be acked in the IDLE cycle that coincides with the completion pulse.
  - Peak throughput is therefore one transaction per 3 cycles.
- Completion pulses are exactly one cycle wide. data_valid and wr_done are never asserted together.

Optional Feature:
- Macro: BIU_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BRESP and increments each BRESP cycle without bus_rvalid.
  - When the count reaches TIMEOUT_CYCLES, the transaction completes: state -> IDLE, next cycle pulse data_valid_ls3 or wr_done_ls3 with buserr_ls3=1 and data_ls3=0.
  - A later stray bus_rvalid is ignored.
  - bus_rvalid on the limit cycle takes priority and completes normally.
- Undefined: no counter; BRESP waits indefinitely.

Test Plan:
- Read: rd_req=1, addr=32'h1004; gnt on cycle 1, rvalid cycle 3 with rdata=64'h123456789ABCDEF0, err=0 -> rd_ack cycle 0, bus_addr=32'h1000, bus_we=0, data_valid_ls3=1 with data_ls3=64'h123456789ABCDEF0 at cycle 4, buserr_ls3=0.
- Write: wr_req=1, addr=32'h2002, wdata=64'h0000_0000_00AA_0000, strb=8'h04; gnt after 3 cycles of bus_req -> bus fields stable across wait, wr_done_ls3 one cycle after rvalid, bus_strb=8'h04.
- Simultaneous: rd_req and wr_req both high in IDLE -> only rd_ack; wr_ack in IDLE after read completion, write issued second.
- Bus error: read with bus_err=1 on rvalid -> data_valid_ls3=1, buserr_ls3=1, data_ls3=0.
- Reset mid-op: resetn=0 while in BRESP, then rvalid after release -> no completion pulse, all outputs 0, next request handled normally.
- Timeout (BIU_TIMEOUT_EN, TIMEOUT_CYCLES=4): read granted, no rvalid -> data_valid_ls3=1 with buserr_ls3=1 five cycles after gnt; a late rvalid produces no pulse.

Source files
------------

// File: rtl/c7bbiu.sv
// c7bbiu: LSU-to-system-bus interface unit. Runs one read or write at a time on a req/gnt/rvalid bus.
// Optional response timeout is compiled in with `define BIU_TIMEOUT_EN.
module c7bbiu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lsu_biu_rd_req_ls2,
  input  logic [31:0] lsu_biu_rd_addr_ls2,
  output logic        biu_lsu_rd_ack_ls2,
  output logic        biu_lsu_data_valid_ls3,
  output logic [63:0] biu_lsu_data_ls3,
  input  logic        lsu_biu_wr_req_ls2,
  input  logic [31:0] lsu_biu_wr_addr_ls2,
  input  logic [63:0] lsu_biu_wr_data_ls2,
  input  logic [7:0]  lsu_biu_wr_strb_ls2,
  output logic        biu_lsu_wr_ack_ls2,
  output logic        biu_lsu_wr_done_ls3,
  output logic        biu_lsu_buserr_ls3,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_strb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [63:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BREQ  = 2'd1,
    BRESP = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("c7bbiu: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t      state_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [63:0] wdata_q;
  logic [7:0]  strb_q;
  logic        req_q;
  logic        dv_q;
  logic        done_q;
  logic        err_q;
  logic [63:0] data_q;

  logic        rd_ack;
  logic        wr_ack;
  logic        timeout;

  // Read has priority; a pending write simply waits for the next IDLE cycle.
  assign rd_ack = (state_q == IDLE) && lsu_biu_rd_req_ls2;
  assign wr_ack = (state_q == IDLE) && lsu_biu_wr_req_ls2 && !lsu_biu_rd_req_ls2;

`ifdef BIU_TIMEOUT_EN
  logic [15:0] cnt_q;
  // cnt_q counts rvalid-less response cycles already elapsed; this cycle would be the last one allowed.
  assign timeout = (state_q == BRESP) && !bus_rvalid
                   && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      req_q   <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
`ifdef BIU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      dv_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_ack) begin
            addr_q  <= lsu_biu_rd_addr_ls2;
            we_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= 8'hFF;
            req_q   <= 1'b1;
            state_q <= BREQ;
          end else if (wr_ack) begin
            addr_q  <= lsu_biu_wr_addr_ls2;
            we_q    <= 1'b1;
            wdata_q <= lsu_biu_wr_data_ls2;
            strb_q  <= lsu_biu_wr_strb_ls2;
            req_q   <= 1'b1;
            state_q <= BREQ;
          end
        end
        BREQ: begin
          if (bus_gnt) begin
            req_q   <= 1'b0;
            state_q <= BRESP;
`ifdef BIU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        BRESP: begin
          if (bus_rvalid) begin
            dv_q    <= !we_q;
            done_q  <= we_q;
            err_q   <= bus_err;
            // Writes leave the read data bus untouched; error reads return zero.
            if (!we_q) begin
              data_q <= bus_err ? 64'd0 : bus_rdata;
            end
            state_q <= IDLE;
          end else if (timeout) begin
            dv_q    <= !we_q;
            done_q  <= we_q;
            err_q   <= 1'b1;
            data_q  <= '0;
            state_q <= IDLE;
          end else begin
`ifdef BIU_TIMEOUT_EN
            cnt_q   <= cnt_q + 16'd1;
`endif
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign biu_lsu_rd_ack_ls2     = rd_ack;
  assign biu_lsu_wr_ack_ls2     = wr_ack;
  assign biu_lsu_data_valid_ls3 = dv_q;
  assign biu_lsu_wr_done_ls3    = done_q;
  assign biu_lsu_buserr_ls3     = err_q;
  assign biu_lsu_data_ls3       = data_q;
  assign bus_req                = req_q;
  assign bus_we                 = we_q;
  assign bus_addr               = addr_q & 32'hFFFF_FFF8;
  assign bus_wdata              = wdata_q;
  assign bus_strb               = strb_q;

endmodule

// File: tb/tb_c7bbiu.sv
// Self-checking bench for c7bbiu: transaction-level model compared every cycle plus directed literal checks.
module tb_c7bbiu;

  localparam int TO = 4;
`ifdef BIU_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        rd_ack;
  logic        dv;
  logic [63:0] dout;
  logic        wr_req = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_strb = '0;
  logic        wr_ack;
  logic        wdone;
  logic        berr;
  logic        breq;
  logic        bwe;
  logic [31:0] baddr;
  logic [63:0] bwdata;
  logic [7:0]  bstrb;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [63:0] rdata = '0;
  logic        err = 1'b0;

  int checks = 0;
  int errors = 0;

  c7bbiu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .lsu_biu_rd_req_ls2(rd_req), .lsu_biu_rd_addr_ls2(rd_addr),
    .biu_lsu_rd_ack_ls2(rd_ack), .biu_lsu_data_valid_ls3(dv), .biu_lsu_data_ls3(dout),
    .lsu_biu_wr_req_ls2(wr_req), .lsu_biu_wr_addr_ls2(wr_addr),
    .lsu_biu_wr_data_ls2(wr_data), .lsu_biu_wr_strb_ls2(wr_strb),
    .biu_lsu_wr_ack_ls2(wr_ack), .biu_lsu_wr_done_ls3(wdone), .biu_lsu_buserr_ls3(berr),
    .bus_req(breq), .bus_we(bwe), .bus_addr(baddr), .bus_wdata(bwdata), .bus_strb(bstrb),
    .bus_gnt(gnt), .bus_rvalid(rvalid), .bus_rdata(rdata), .bus_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding op, phases "waiting for grant" / "waiting for response".
  bit          m_busy = 0, m_issued = 0, m_we = 0;
  bit [31:0]   m_addr = 0;
  bit [63:0]   m_wdata = 0;
  bit [7:0]    m_strb = 0;
  int          m_wait = 0;
  bit          m_dv = 0, m_done = 0, m_err = 0;
  bit [63:0]   m_data = 0;

  task automatic m_finish(input bit e, input bit [63:0] d, input bit force_data);
    m_busy = 0;
    m_issued = 0;
    m_err = e;
    if (m_we) m_done = 1; else m_dv = 1;
    if (!m_we || force_data) m_data = d;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy = 0; m_issued = 0; m_wait = 0;
      m_dv = 0; m_done = 0; m_err = 0; m_data = 0;
    end else begin
      m_dv = 0; m_done = 0; m_err = 0;
      if (m_busy && m_issued) begin
        if (rvalid) m_finish(err, err ? 64'd0 : rdata, 1'b0);
        else if (TO_EN && (m_wait + 1 >= TO)) m_finish(1'b1, 64'd0, 1'b1);
        else m_wait++;
      end else if (m_busy) begin
        if (gnt) begin m_issued = 1; m_wait = 0; end
      end else if (rd_req) begin
        m_busy = 1; m_we = 0; m_addr = {rd_addr[31:3], 3'b000};
        m_wdata = 0; m_strb = 8'hFF;
      end else if (wr_req) begin
        m_busy = 1; m_we = 1; m_addr = {wr_addr[31:3], 3'b000};
        m_wdata = wr_data; m_strb = wr_strb;
      end
    end
  end

  always @(negedge clk) begin
    chk("rd_ack", rd_ack, !m_busy && rd_req);
    chk("wr_ack", wr_ack, !m_busy && wr_req && !rd_req);
    chk("bus_req", breq, m_busy && !m_issued);
    chk("data_valid", dv, m_dv);
    chk("wr_done", wdone, m_done);
    chk("buserr", berr, m_err);
    chk("data_ls3", dout, m_data);
    if (m_busy && !m_issued) begin
      chk("bus_we", bwe, m_we);
      chk("bus_addr", baddr, m_addr);
      chk("bus_wdata", bwdata, m_wdata);
      chk("bus_strb", bstrb, m_strb);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tick(2);
    chk("rst bus_req", breq, 0);
    chk("rst data_ls3", dout, 0);
    chk("rst bus_addr", baddr, 0);
    chk("rst bus_wdata", bwdata, 0);
    chk("rst bus_strb", bstrb, 0);
    resetn = 1'b1;
    tick();

    // Read: gnt cycle 1, rvalid cycle 3, completion cycle 4
    rd_req = 1; rd_addr = 32'h1004;
    #1 chk("T1 rd_ack", rd_ack, 1);
    tick(); rd_req = 0; gnt = 1;
    #1 chk("T1 bus_addr", baddr, 32'h1000);
    chk("T1 bus_we", bwe, 0);
    chk("T1 bus_strb", bstrb, 8'hFF);
    tick(); gnt = 0;
    tick(); rvalid = 1; rdata = 64'h123456789ABCDEF0;
    tick(); rvalid = 0; rdata = 0;
    chk("T1 data_valid", dv, 1);
    chk("T1 data", dout, 64'h123456789ABCDEF0);
    chk("T1 buserr", berr, 0);
    tick();
    chk("T1 pulse width", dv, 0);
    chk("T1 data hold", dout, 64'h123456789ABCDEF0);

    // Write: grant delayed 3 cycles, a stray rvalid while waiting for grant
    wr_req = 1; wr_addr = 32'h2002; wr_data = 64'h0000_0000_00AA_0000; wr_strb = 8'h04;
    #1 chk("T2 wr_ack", wr_ack, 1);
    tick(); wr_req = 0; wr_data = 0; wr_strb = 0;
    tick(); rvalid = 1;
    tick(); rvalid = 0;
    chk("T2 bus_strb wait", bstrb, 8'h04);
    chk("T2 bus_addr wait", baddr, 32'h2000);
    chk("T2 no early done", wdone, 0);
    tick(); gnt = 1;
    tick(); gnt = 0; rvalid = 1;
    tick(); rvalid = 0;
    chk("T2 wr_done", wdone, 1);
    chk("T2 no data_valid", dv, 0);
    chk("T2 data untouched", dout, 64'h123456789ABCDEF0);

    // Bus error on a read
    rd_req = 1; rd_addr = 32'h300C;
    tick(); rd_req = 0; gnt = 1;
    tick(); gnt = 0; rvalid = 1; err = 1; rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(); rvalid = 0; err = 0; rdata = 0;
    chk("T4 data_valid", dv, 1);
    chk("T4 buserr", berr, 1);
    chk("T4 data zero", dout, 0);

    // Simultaneous requests: read first, write acked on the completion cycle
    rd_req = 1; rd_addr = 32'h4000;
    wr_req = 1; wr_addr = 32'h5010; wr_data = 64'h1111_2222_3333_4444; wr_strb = 8'hF0;
    #1 chk("T3 rd_ack", rd_ack, 1);
    chk("T3 wr_ack", wr_ack, 0);
    tick(); rd_req = 0; gnt = 1;
    #1 chk("T3 wr_ack busy", wr_ack, 0);
    chk("T3 read first", bwe, 0);
    tick(); gnt = 0; rvalid = 1; rdata = 64'hCAFEF00D_0BADBEEF;
    tick(); rvalid = 0; rdata = 0;
    chk("T3 read done", dv, 1);
    chk("T3 read data", dout, 64'hCAFEF00D_0BADBEEF);
    chk("T3 wr_ack idle", wr_ack, 1);
    tick(); wr_req = 0; gnt = 1;
    #1 chk("T3 write second", bwe, 1);
    chk("T3 write addr", baddr, 32'h5010);
    tick(); gnt = 0; rvalid = 1;
    tick(); rvalid = 0;
    chk("T3 wr_done", wdone, 1);

    // Reset while waiting for the response
    rd_req = 1; rd_addr = 32'h6008;
    tick(); rd_req = 0; gnt = 1;
    tick(); gnt = 0; resetn = 0;
    #1 chk("T5 rst data", dout, 0);
    chk("T5 rst bus_req", breq, 0);
    chk("T5 rst bus_addr", baddr, 0);
    chk("T5 rst bus_strb", bstrb, 0);
    tick(2); resetn = 1;
    tick(); rvalid = 1; rdata = 64'hDEAD;
    tick(); rvalid = 0; rdata = 0;
    chk("T5 no pulse dv", dv, 0);
    chk("T5 no pulse done", wdone, 0);
    wr_req = 1; wr_addr = 32'h7000; wr_data = 64'h55; wr_strb = 8'h01;
    #1 chk("T5 new wr_ack", wr_ack, 1);
    tick(); wr_req = 0; gnt = 1;
    tick(); gnt = 0; rvalid = 1;
    tick(); rvalid = 0;
    chk("T5 new wr_done", wdone, 1);
    tick();

`ifdef BIU_TIMEOUT_EN
    // Timeout: gnt at cycle 1, error completion at cycle 6, late rvalid ignored
    rd_req = 1; rd_addr = 32'h8000;
    tick(); rd_req = 0; gnt = 1;
    tick(); gnt = 0;
    tick(3);
    chk("T6 not yet", dv, 0);
    tick();
    chk("T6 timeout dv", dv, 1);
    chk("T6 timeout err", berr, 1);
    chk("T6 timeout data", dout, 0);
    rvalid = 1; rdata = 64'hBEEF;
    tick(); rvalid = 0; rdata = 0;
    tick();
    chk("T6 late rvalid", dv, 0);
`endif

    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
